// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode decoding, the idle byte sent on TX underrun, and
// the per-cycle event bundle produced by the pin edge detector.
package spi_pkg;

    localparam logic [7:0] DEFAULT_TX_BYTE = 8'hFF;

    // Modes 2 and 3 idle SCK high; modes 1 and 3 sample on the trailing edge.
    function automatic logic spi_cpol(input int mode);
        return (mode == 2) || (mode == 3);
    endfunction

    function automatic logic spi_cpha(input int mode);
        return (mode == 1) || (mode == 3);
    endfunction

    typedef struct packed {
        logic cs_fall;
        logic cs_rise;
        logic lead;
        logic trail;
    } spi_evt_t;

endpackage

// File: rtl/spi_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset value so the synced output starts at the pin's idle level.
module spi_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
    end

    always_ff @(posedge i_Clk) begin
        if (!rstn) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/spi_slave.sv
// SPI peripheral: oversamples SCK/CS_n/MOSI in the i_Clk domain, shifts a byte in
// and out per 8 SCK cycles, and offers a TX holding register and an RX pulse.
module spi_slave
    import spi_pkg::*;
#(
    parameter int         SPI_MODE   = 0,
    parameter logic [7:0] DEFAULT_TX = DEFAULT_TX_BYTE
) (
    input  logic       i_Clk,
    input  logic       rstn,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_TX_Underrun,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_Busy,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En
);

    localparam logic CPOL = spi_cpol(SPI_MODE);
    localparam logic CPHA = spi_cpha(SPI_MODE);

    logic sck_s, cs_s, mosi_s;

    spi_sync_2ff #(.RST_VAL(CPOL)) u_sync_sck (
        .i_Clk  (i_Clk),
        .rstn   (rstn),
        .i_async(i_SPI_Clk),
        .o_sync (sck_s)
    );

    spi_sync_2ff #(.RST_VAL(1'b1)) u_sync_cs (
        .i_Clk  (i_Clk),
        .rstn   (rstn),
        .i_async(i_SPI_CS_n),
        .o_sync (cs_s)
    );

    spi_sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_Clk  (i_Clk),
        .rstn   (rstn),
        .i_async(i_SPI_MOSI),
        .o_sync (mosi_s)
    );

    logic       sck_d_q, sck_d_d;
    logic       cs_d_q, cs_d_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic       tx_fresh_q, tx_fresh_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic       underrun_q, underrun_d;
    logic       miso_q, miso_d;

    spi_evt_t   evt;
    logic       sample_evt, drive_evt;
    logic [7:0] next_byte;
    logic       load_req;

    always_comb begin
        evt.cs_fall = cs_d_q & ~cs_s;
        evt.cs_rise = ~cs_d_q & cs_s;
        evt.lead    = ~cs_s & (sck_d_q == CPOL) & (sck_s != CPOL);
        evt.trail   = ~cs_s & (sck_d_q != CPOL) & (sck_s == CPOL);
        sample_evt  = CPHA ? evt.trail : evt.lead;
        drive_evt   = CPHA ? evt.lead  : evt.trail;
    end

    // Byte source for any shift-register load: holding first, then a same-cycle
    // strobe straight through, otherwise the underrun filler.
    always_comb begin
        if (hold_full_q) begin
            next_byte = hold_q;
        end else if (i_TX_DV) begin
            next_byte = i_TX_Byte;
        end else begin
            next_byte = DEFAULT_TX;
        end
    end

    always_comb begin
        sck_d_d     = sck_s;
        cs_d_d      = cs_s;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_shift_d  = tx_shift_q;
        tx_cnt_d    = tx_cnt_q;
        tx_fresh_d  = tx_fresh_q;
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        underrun_d  = 1'b0;
        miso_d      = miso_q;
        load_req    = 1'b0;

        if (evt.cs_rise) begin
            tx_shift_d = 8'h00;
            tx_cnt_d   = 3'd7;
            tx_fresh_d = 1'b0;
            rx_shift_d = 8'h00;
            rx_cnt_d   = 3'd7;
            miso_d     = 1'b0;
        end else if (evt.cs_fall) begin
            load_req   = 1'b1;
            tx_shift_d = next_byte;
            tx_cnt_d   = 3'd7;
            tx_fresh_d = 1'b1;
            rx_shift_d = 8'h00;
            rx_cnt_d   = 3'd7;
            if (!CPHA) begin
                miso_d = next_byte[7];
            end
        end else begin
            if (sample_evt) begin
                rx_shift_d[rx_cnt_q] = mosi_s;
                if (rx_cnt_q == 3'd0) begin
                    rx_byte_d = rx_shift_d;
                    rx_dv_d   = 1'b1;
                    rx_cnt_d  = 3'd7;
                end else begin
                    rx_cnt_d = rx_cnt_q - 3'd1;
                end
            end

            // CPHA=0: tx_cnt is the bit on the pin. CPHA=1: the bit to drive
            // next, with tx_fresh marking the byte already loaded at frame start.
            if (drive_evt) begin
                if (!CPHA) begin
                    if (tx_cnt_q == 3'd0) begin
                        load_req   = 1'b1;
                        tx_shift_d = next_byte;
                        tx_cnt_d   = 3'd7;
                        miso_d     = next_byte[7];
                    end else begin
                        tx_cnt_d = tx_cnt_q - 3'd1;
                        miso_d   = tx_shift_q[tx_cnt_q - 3'd1];
                    end
                end else begin
                    if (tx_cnt_q == 3'd7) begin
                        if (!tx_fresh_q) begin
                            load_req   = 1'b1;
                            tx_shift_d = next_byte;
                            miso_d     = next_byte[7];
                        end else begin
                            miso_d = tx_shift_q[7];
                        end
                        tx_fresh_d = 1'b0;
                        tx_cnt_d   = 3'd6;
                    end else begin
                        miso_d   = tx_shift_q[tx_cnt_q];
                        tx_cnt_d = tx_cnt_q - 3'd1;
                    end
                end
            end
        end

        if (load_req) begin
            if (hold_full_q) begin
                hold_full_d = 1'b0;
            end else if (!i_TX_DV) begin
                underrun_d = 1'b1;
            end
        end else if (i_TX_DV && !hold_full_q) begin
            hold_d      = i_TX_Byte;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!rstn) begin
            sck_d_q     <= CPOL;
            cs_d_q      <= 1'b1;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_shift_q  <= 8'h00;
            tx_cnt_q    <= 3'd7;
            tx_fresh_q  <= 1'b0;
            rx_shift_q  <= 8'h00;
            rx_cnt_q    <= 3'd7;
            rx_byte_q   <= 8'h00;
            rx_dv_q     <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            sck_d_q     <= sck_d_d;
            cs_d_q      <= cs_d_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_fresh_q  <= tx_fresh_d;
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            underrun_q  <= underrun_d;
            miso_q      <= miso_d;
        end
    end

    assign o_TX_Ready    = ~hold_full_q;
    assign o_TX_Underrun = underrun_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_RX_Byte     = rx_byte_q;
    assign o_Busy        = ~cs_s;
    assign o_SPI_MISO    = miso_q;
    assign o_SPI_MISO_En = ~cs_s;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode driven by a bit-banged master,
// with expected RX and MISO bytes queued at stimulus time and popped by a monitor.
module tb_spi_slave;

    logic       i_Clk = 1'b0;
    logic       rstn;
    logic [7:0] tx_byte;
    logic [3:0] tx_dv;
    logic [3:0] tx_ready, underrun, rx_dv, busy, miso, miso_en;
    logic [7:0] rx_byte [4];
    logic [3:0] sck, cs_n;
    logic       mosi;

    always #5 i_Clk = ~i_Clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(.SPI_MODE(g)) u_dut (
            .i_Clk        (i_Clk),
            .rstn         (rstn),
            .i_TX_Byte    (tx_byte),
            .i_TX_DV      (tx_dv[g]),
            .o_TX_Ready   (tx_ready[g]),
            .o_TX_Underrun(underrun[g]),
            .o_RX_DV      (rx_dv[g]),
            .o_RX_Byte    (rx_byte[g]),
            .o_Busy       (busy[g]),
            .i_SPI_Clk    (sck[g]),
            .i_SPI_CS_n   (cs_n[g]),
            .i_SPI_MOSI   (mosi),
            .o_SPI_MISO   (miso[g]),
            .o_SPI_MISO_En(miso_en[g])
        );
    end

    int         checks = 0;
    int         failures = 0;
    int         active_mode = 0;
    int         und_cnt [4] = '{0, 0, 0, 0};
    logic [7:0] rx_exp_q [$];
    logic [7:0] miso_exp_q [$];
    logic [7:0] miso_got_q [$];
    logic [7:0] mosi_bytes [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents an RX byte or the
    // master finishes capturing a MISO byte.
    always @(negedge i_Clk) begin
        for (int m = 0; m < 4; m++) begin
            if (underrun[m]) und_cnt[m]++;
            if (rx_dv[m]) begin
                check("rx_dv_mode", 32'(m), 32'(active_mode));
                if (rx_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected got=%0h exp=none", rx_byte[m]);
                end else begin
                    check("rx_byte", 32'(rx_byte[m]), 32'(rx_exp_q.pop_front()));
                end
            end
        end
        if (miso_got_q.size() > 0) begin
            if (miso_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL miso_unexpected got=%0h exp=none", miso_got_q.pop_front());
            end else begin
                check("miso_byte", 32'(miso_got_q.pop_front()), 32'(miso_exp_q.pop_front()));
            end
        end
    end

    task automatic tx_load(input int m, input logic [7:0] b);
        @(negedge i_Clk);
        tx_byte   = b;
        tx_dv[m]  = 1'b1;
        @(negedge i_Clk);
        tx_dv[m]  = 1'b0;
    endtask

    task automatic wait_ready(input int m);
        int n = 0;
        while (!tx_ready[m] && n < 2000) begin
            @(negedge i_Clk);
            n++;
        end
        check("tx_ready_wait", 32'(tx_ready[m]), 32'd1);
    endtask

    // SCK half period is 4 i_Clk cycles. abort_bits>0 ends the frame early,
    // either by raising CS_n or (abort_rst) by pulsing reset with CS_n still low.
    task automatic spi_frame(input int m, input int nbytes, input int abort_bits, input bit abort_rst);
        logic       cpol, cpha;
        logic [7:0] got;
        int         total;
        cpol  = (m >= 2);
        cpha  = (m % 2 == 1);
        got   = 8'h00;
        total = (abort_bits > 0) ? abort_bits : nbytes * 8;
        active_mode = m;
        @(negedge i_Clk);
        cs_n[m] = 1'b0;
        mosi    = mosi_bytes[0][7];
        repeat (8) @(negedge i_Clk);
        check("busy_in_frame", 32'(busy[m]), 32'd1);
        check("miso_en_in_frame", 32'(miso_en[m]), 32'd1);
        for (int k = 0; k < total; k++) begin
            if (cpha) mosi = mosi_bytes[k / 8][7 - (k % 8)];
            else got[7 - (k % 8)] = miso[m];
            sck[m] = ~cpol;
            repeat (4) @(negedge i_Clk);
            if (cpha) got[7 - (k % 8)] = miso[m];
            sck[m] = cpol;
            if (!cpha && (k + 1 < total)) mosi = mosi_bytes[(k + 1) / 8][7 - ((k + 1) % 8)];
            if (k % 8 == 7) miso_got_q.push_back(got);
            repeat (4) @(negedge i_Clk);
        end
        if (abort_rst) begin
            rstn    = 1'b0;
            cs_n[m] = 1'b1;
            @(negedge i_Clk);
            check("rst_tx_ready", 32'(tx_ready), 32'hF);
            check("rst_underrun", 32'(underrun), 32'h0);
            check("rst_rx_dv", 32'(rx_dv), 32'h0);
            check("rst_rx_byte", 32'(rx_byte[m]), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_miso", 32'(miso), 32'h0);
            check("rst_miso_en", 32'(miso_en), 32'h0);
            repeat (2) @(negedge i_Clk);
            rstn = 1'b1;
        end else begin
            repeat (4) @(negedge i_Clk);
            cs_n[m] = 1'b1;
        end
        repeat (8) @(negedge i_Clk);
        check("busy_after_frame", 32'(busy[m]), 32'd0);
        check("miso_after_frame", 32'(miso[m]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn    = 1'b0;
        tx_dv   = 4'h0;
        tx_byte = 8'h00;
        sck     = 4'b1100;
        cs_n    = 4'hF;
        mosi    = 1'b0;
        repeat (3) @(negedge i_Clk);
        check("reset_tx_ready", 32'(tx_ready), 32'hF);
        check("reset_underrun", 32'(underrun), 32'h0);
        check("reset_rx_dv", 32'(rx_dv), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_miso", 32'(miso), 32'h0);
        check("reset_miso_en", 32'(miso_en), 32'h0);
        check("reset_rx_byte", 32'(rx_byte[0]), 32'h0);
        rstn = 1'b1;
        repeat (4) @(negedge i_Clk);

        // Mode 0 single byte with preloaded TX
        tx_load(0, 8'hA5);
        check("t1_ready_low", 32'(tx_ready[0]), 32'd0);
        mosi_bytes[0] = 8'h3C;
        rx_exp_q.push_back(8'h3C);
        miso_exp_q.push_back(8'hA5);
        spi_frame(0, 1, 0, 1'b0);
        check("t1_ready_back", 32'(tx_ready[0]), 32'd1);

        // Mode 3 four back-to-back bytes with reloads
        tx_load(3, 8'hB1);
        mosi_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        rx_exp_q.push_back(8'h01); rx_exp_q.push_back(8'h02);
        rx_exp_q.push_back(8'h03); rx_exp_q.push_back(8'h04);
        miso_exp_q.push_back(8'hB1); miso_exp_q.push_back(8'hB2);
        miso_exp_q.push_back(8'hB3); miso_exp_q.push_back(8'hB4);
        fork
            spi_frame(3, 4, 0, 1'b0);
            begin
                wait_ready(3); tx_load(3, 8'hB2);
                wait_ready(3); tx_load(3, 8'hB3);
                wait_ready(3); tx_load(3, 8'hB4);
            end
        join

        // Mode 1 underrun: nothing loaded, two bytes
        begin
            int u0;
            u0 = und_cnt[1];
            mosi_bytes[0] = 8'hE7;
            mosi_bytes[1] = 8'h18;
            rx_exp_q.push_back(8'hE7); rx_exp_q.push_back(8'h18);
            miso_exp_q.push_back(8'hFF); miso_exp_q.push_back(8'hFF);
            spi_frame(1, 2, 0, 1'b0);
            check("t3_underruns", 32'(und_cnt[1] - u0), 32'd2);
        end

        // Mode 0 partial byte aborted by CS_n, then a full frame
        mosi_bytes[0] = 8'hF0;
        spi_frame(0, 1, 5, 1'b0);
        mosi_bytes[0] = 8'h81;
        rx_exp_q.push_back(8'h81);
        miso_exp_q.push_back(8'hFF);
        spi_frame(0, 1, 0, 1'b0);

        // Mode 0 second load while holding is full is dropped
        tx_load(0, 8'h11);
        tx_load(0, 8'h22);
        mosi_bytes[0] = 8'h55;
        mosi_bytes[1] = 8'hAA;
        rx_exp_q.push_back(8'h55); rx_exp_q.push_back(8'hAA);
        miso_exp_q.push_back(8'h11); miso_exp_q.push_back(8'hFF);
        spi_frame(0, 2, 0, 1'b0);

        // Mode 2: good frame, reset mid-byte with holding full, good frame
        tx_load(2, 8'h5A);
        mosi_bytes[0] = 8'hC3;
        rx_exp_q.push_back(8'hC3);
        miso_exp_q.push_back(8'h5A);
        spi_frame(2, 1, 0, 1'b0);
        mosi_bytes[0] = 8'h0F;
        fork
            spi_frame(2, 1, 3, 1'b1);
            begin
                repeat (20) @(negedge i_Clk);
                tx_load(2, 8'h77);
            end
        join
        tx_load(2, 8'h69);
        mosi_bytes[0] = 8'h96;
        rx_exp_q.push_back(8'h96);
        miso_exp_q.push_back(8'h69);
        spi_frame(2, 1, 0, 1'b0);

        repeat (10) @(negedge i_Clk);
        check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
        check("miso_queue_drained", 32'(miso_exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI peripheral (slave) end of the SPI link, the counterpart to our SPI master.
- Lets the SoC be driven by an external SPI master, e.g. a host MCU or a test controller.
- Oversamples SCK, CS_n and MOSI in the i_Clk domain. Shifts a byte in on MOSI and out on MISO per 8 SCK cycles while CS_n is low.
- Presents a byte-level valid/ready interface to the local bus wrapper: one holding register for TX, a 1-cycle pulse for RX.

Parameters:
- SPI_MODE, 0, SPI mode 0-3; CPOL = mode 2 or 3, CPHA = mode 1 or 3.
- DEFAULT_TX, 8'hFF, byte shifted out when no TX data is loaded (underrun).

Ports:
- i_Clk  in  1  system clock; must be >= 4x the SCK frequency.
- rstn  in  1  reset, synchronous, active-low.
- i_TX_Byte  in  8  next byte to send on MISO.
- i_TX_DV  in  1  1-cycle load strobe for i_TX_Byte.
- o_TX_Ready  out  1  holding register empty; may load.
- o_TX_Underrun  out  1  1-cycle pulse: DEFAULT_TX was used for a byte.
- o_RX_DV  out  1  1-cycle pulse: o_RX_Byte valid.
- o_RX_Byte  out  8  last complete received byte.
- o_Busy  out  1  synchronised CS_n is low.
- i_SPI_Clk  in  1  SCK from master (async).
- i_SPI_CS_n  in  1  chip select, active-low (async).
- i_SPI_MOSI  in  1  serial data in (async).
- o_SPI_MISO  out  1  serial data out.
- o_SPI_MISO_En  out  1  MISO output enable; equals o_Busy.

Behaviour:
- Reset (rstn=0 at posedge i_Clk):
  - o_TX_Ready=1, o_TX_Underrun=0, o_RX_DV=0, o_RX_Byte=0, o_Busy=0, o_SPI_MISO=0, o_SPI_MISO_En=0.
  - Holding register empty, bit counters = 7, synchroniser flops = idle (SCK=CPOL, CS_n=1, MOSI=0).
  - Reset mid-transfer aborts immediately; the partial byte is lost.
- Synchronisation and edges:
  - SCK, CS_n and MOSI each pass through a 2-flop synchroniser.
  - Edge detect compares the synced value with a third flop.
  - Leading edge = synced SCK leaves CPOL; trailing edge = synced SCK returns to CPOL.
  - Internal event fires 3 i_Clk cycles after the pin transition. Edges are ignored while synced CS_n=1.
- Frame start (synced CS_n falls):
  - RX and TX bit counters set to 7.
  - Shift register loads holding (holding then empty) or DEFAULT_TX plus an o_TX_Underrun pulse.
  - CPHA=0: o_SPI_MISO = bit 7 in the same cycle as the load.
- Sampling:
  - MOSI is sampled on the leading edge (CPHA=0) or the trailing edge (CPHA=1), MSB first, into rx_shift[rx_cnt]; rx_cnt decrements.
  - When bit 0 is sampled: o_RX_Byte updates and o_RX_DV=1 in the next cycle, for 1 cycle. rx_cnt wraps to 7.
- Shifting out:
  - MISO changes on the trailing edge (CPHA=0) or the leading edge (CPHA=1).
  - CPHA=0: at the trailing edge after bit 0 is sampled, the next byte is loaded (holding or DEFAULT_TX) and bit 7 driven.
  - CPHA=1: at the leading edge with tx_cnt=7, the shift register is loaded and bit 7 driven; other leading edges drive tx_cnt bit.
  - Back-to-back bytes within one CS_n assertion are unlimited.
- TX handshake:
  - i_TX_DV with o_TX_Ready=1 writes holding; o_TX_Ready=0 the next cycle.
  - i_TX_DV with o_TX_Ready=0 is ignored (no overwrite).
  - i_TX_DV coinciding with a load event while holding is empty bypasses holding into the shift register. No underrun; o_TX_Ready stays 1.
  - o_TX_Ready returns to 1 the cycle after holding is consumed.
- CS_n rises mid-byte:
  - Partial RX discarded (no o_RX_DV), counters to 7, shift register discarded.
  - An unconsumed holding byte is kept. o_SPI_MISO_En=0, o_SPI_MISO=0.
- o_Busy and o_SPI_MISO_En follow synced CS_n (2-cycle latency).

Decomposition:
- Package spi_pkg:
  - functions/constants deriving CPOL and CPHA from SPI_MODE (shared with the master);
  - default DEFAULT_TX constant.
- One sub-module, spi_sync_2ff (1-bit, parameterised reset value), instantiated 3 times; reusable by other async inputs.

Test Plan:
1. Mode 0, SCK = i_Clk/8, i_TX_DV with 8'hA5 before CS_n falls; master sends 8'h3C -> master receives 8'hA5; o_RX_DV pulses once with o_RX_Byte=8'h3C; o_TX_Ready returns to 1 after frame start.
2. Mode 3, 4 back-to-back bytes in one CS_n (MOSI 01,02,03,04), TX reloaded after each o_TX_Ready -> 4 o_RX_DV pulses in order; MISO delivers the 4 loaded bytes.
3. No TX load, mode 1 -> MISO byte = 8'hFF; o_TX_Underrun pulses once per byte.
4. CS_n deasserted after 5 SCK cycles, then a new full frame with MOSI 8'h81 -> no o_RX_DV for the partial byte; next frame o_RX_Byte=8'h81.
5. i_TX_DV 8'h11 then i_TX_DV 8'h22 while o_TX_Ready=0 -> MISO sends 8'h11; 8'h22 dropped.
6. rstn asserted mid-byte (mode 2) -> all outputs at reset values next cycle; following frame works normally.
